instruction_encoder_loader: RTL and testbench
=============================================

// Module: instruction_encoder_loader
// PURPOSE
//  Encoder/writer counterpart of the processor's instruction field decode: accepts
//  decoded instruction fields over a valid/ready stream, packs each into the 32-bit
//  ISA word (R/I/JI/JII formats) and writes it into instruction memory at sequential
//  addresses. Used by the bench/boot path to load programs into imem before the
//  processor is released from reset.
// PARAMETERS
//  ADDR_W     12  imem address width (words)
//  BASE_ADDR  0   first write address after start
// PORTS
//  clock        in   1       single clock, rising edge
//  reset        in   1       synchronous, active-high
//  start        in   1       pulse: begin a load session
//  in_valid     in   1       field tuple valid
//  in_ready     out  1       encoder can accept a tuple this cycle
//  in_opcode    in   5       word[31:27]
//  in_rd        in   5       word[26:22]
//  in_rs        in   5       word[21:17]
//  in_rt        in   5       word[16:12] (R-type)
//  in_shamt     in   5       word[11:7]  (R-type)
//  in_alu_op    in   5       word[6:2]   (R-type)
//  in_imm       in   17      word[16:0]  (I-type)
//  in_target    in   27      word[26:0]  (JI-type)
//  in_last      in   1       this tuple ends the program
//  imem_wren    out  1       imem write strobe
//  imem_addr    out  ADDR_W  imem write address
//  imem_data    out  32      encoded instruction
//  busy         out  1       state==LOAD
//  done         out  1       state==DONE (level)
//  word_count   out  ADDR_W+1 words written this session
//  err_illegal  out  1       sticky: unknown opcode seen this session
//  err_overflow out  1       sticky: address space exhausted before in_last
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; addr ptr=BASE_ADDR; pending write dropped.
//  - FSM IDLE -start-> LOAD; LOAD -accept w/ in_last, or accept at addr ptr=2^ADDR_W-1-> DONE;
//    DONE -start-> LOAD. start in LOAD ignored.
//  - Entering LOAD: ptr=BASE_ADDR, word_count=0, err flags cleared.
//  - in_ready = (state==LOAD). Accept = in_valid & in_ready. No backpressure from imem.
//  - Latency 1: tuple accepted in cycle N -> imem_wren=1, imem_addr=ptr, imem_data=word
//    in cycle N+1; ptr and word_count increment with the accept. imem_wren=0 otherwise.
//  - Format select by in_opcode:
//    R   00000: {op,rd,rs,rt,shamt,alu_op,2'b00}
//    JI  00001,00011,10101,10110: {op,target}
//    JII 00100: {op,rd,22'b0}
//    I   00010,00101,00110,00111,01000: {op,rd,rs,imm}
//    other: imem_data=32'h0 (nop) still written; err_illegal set.
//  - Overflow: accept at ptr=2^ADDR_W-1 without in_last -> word written at max addr,
//    err_overflow set, DONE; ptr does not wrap. With in_last -> no error.
//  - Final write is issued in the first DONE cycle; done rises with it.
//  - Reset mid-LOAD returns to IDLE; any registered-but-unissued write is lost.
// TESTING
//  - start; R tuple op0 rd3 rs1 rt2 shamt0 alu_op0 last=1 -> next cycle wren, addr0,
//    data 32'h00C22000; done=1, word_count=1.
//  - addi rd1 rs0 imm 17'h1FFFF, then j target 27'h123 last -> addr0 32'h2841FFFF,
//    addr1 32'h08000123.
//  - opcode 01111 -> data 0 written, err_illegal=1; next start clears it.
//  - ADDR_W=2, 5 tuples none last -> writes addr0..3, err_overflow=1, 5th not accepted.
//  - reset asserted cycle after accept -> imem_wren stays 0, busy=0, word_count=0.
//  - in_valid toggled randomly over 8 tuples -> addresses contiguous, no gaps/dupes.

Source files
------------

// File: rtl/instruction_encoder_loader.sv
// Packs decoded instruction fields into 32-bit ISA words and writes them to
// instruction memory at sequential addresses during a start-triggered load session.
module instruction_encoder_loader #(
  parameter int ADDR_W    = 12,
  parameter int BASE_ADDR = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_shamt,
  input  logic [4:0]        in_alu_op,
  input  logic [16:0]       in_imm,
  input  logic [26:0]       in_target,
  input  logic              in_last,
  output logic              imem_wren,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              err_illegal,
  output logic              err_overflow
);

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] MAX_ADDR = '1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [31:0]       enc_word;
  logic              enc_illegal;
  logic              accept;

  assign in_ready = (state == LOAD);
  assign busy     = (state == LOAD);
  assign done     = (state == DONE);
  assign accept   = in_valid && in_ready;

  always_comb begin
    enc_word    = 32'h0;
    enc_illegal = 1'b0;
    case (in_opcode)
      5'b00000:
        enc_word = {in_opcode, in_rd, in_rs, in_rt, in_shamt, in_alu_op, 2'b00};
      5'b00001, 5'b00011, 5'b10101, 5'b10110:
        enc_word = {in_opcode, in_target};
      5'b00100:
        enc_word = {in_opcode, in_rd, 22'b0};
      5'b00010, 5'b00101, 5'b00110, 5'b00111, 5'b01000:
        enc_word = {in_opcode, in_rd, in_rs, in_imm};
      default:
        enc_illegal = 1'b1;  // still written as a nop so the address stream stays dense
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      ptr          <= BASE;
      word_count   <= '0;
      err_illegal  <= 1'b0;
      err_overflow <= 1'b0;
      imem_wren    <= 1'b0;
      imem_addr    <= '0;
      imem_data    <= 32'h0;
    end else begin
      imem_wren <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= LOAD;
            ptr          <= BASE;
            word_count   <= '0;
            err_illegal  <= 1'b0;
            err_overflow <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            imem_wren  <= 1'b1;
            imem_addr  <= ptr;
            imem_data  <= enc_word;
            word_count <= word_count + 1'b1;
            if (enc_illegal) err_illegal <= 1'b1;
            // The pointer saturates at the top word; the session ends there.
            if (ptr == MAX_ADDR) begin
              state <= DONE;
              if (!in_last) err_overflow <= 1'b1;
            end else begin
              ptr <= ptr + 1'b1;
              if (in_last) state <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_encoder_loader.sv
// Randomized scoreboard bench: drivers push expected imem writes, a negedge monitor
// pops and compares every write; a small ADDR_W=2 instance covers overflow.
module tb_instruction_encoder_loader;

  logic        clock = 0;
  logic        reset = 1;
  logic        start = 0, start2 = 0;
  logic        in_valid = 0, in_valid2 = 0;
  logic        in_last = 0, in_last2 = 0;
  logic [4:0]  in_opcode = 0, in_rd = 0, in_rs = 0, in_rt = 0, in_shamt = 0, in_alu_op = 0;
  logic [16:0] in_imm = 0;
  logic [26:0] in_target = 0;

  logic        in_ready, imem_wren, busy, done, err_illegal, err_overflow;
  logic [11:0] imem_addr;
  logic [31:0] imem_data;
  logic [12:0] word_count;

  logic        in_ready2, imem_wren2, busy2, done2, err_illegal2, err_overflow2;
  logic [1:0]  imem_addr2;
  logic [31:0] imem_data2;
  logic [2:0]  word_count2;

  instruction_encoder_loader #(.ADDR_W(12), .BASE_ADDR(0)) dut (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_shamt(in_shamt),
    .in_alu_op(in_alu_op), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
    .imem_wren(imem_wren), .imem_addr(imem_addr), .imem_data(imem_data), .busy(busy),
    .done(done), .word_count(word_count), .err_illegal(err_illegal), .err_overflow(err_overflow)
  );

  instruction_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut_small (
    .clock(clock), .reset(reset), .start(start2), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_shamt(in_shamt),
    .in_alu_op(in_alu_op), .in_imm(in_imm), .in_target(in_target), .in_last(in_last2),
    .imem_wren(imem_wren2), .imem_addr(imem_addr2), .imem_data(imem_data2), .busy(busy2),
    .done(done2), .word_count(word_count2), .err_illegal(err_illegal2), .err_overflow(err_overflow2)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  exp_t q2[$];
  int   checks = 0;
  int   passed = 0;

  // Reference model state for the main instance
  int   m_ptr = 0;
  int   m_wc = 0;
  bit   m_ill = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  // Word layout from the ISA field positions, built arithmetically.
  function automatic logic [31:0] model_word(input logic [4:0] op, rd, rs, rt, sh, alu,
                                             input logic [16:0] imm, input logic [26:0] tgt,
                                             output bit bad);
    logic [31:0] o;
    o   = 32'(op) << 27;
    bad = 0;
    if (op == 0)
      return o | (32'(rd) << 22) | (32'(rs) << 17) | (32'(rt) << 12) | (32'(sh) << 7) | (32'(alu) << 2);
    if (op == 1 || op == 3 || op == 21 || op == 22)
      return o | 32'(tgt);
    if (op == 4)
      return o | (32'(rd) << 22);
    if (op == 2 || (op >= 5 && op <= 8))
      return o | (32'(rd) << 22) | (32'(rs) << 17) | 32'(imm);
    bad = 1;
    return 32'h0;
  endfunction

  always @(negedge clock) begin
    if (imem_wren) begin
      $display("write main addr=%0h data=%08h", imem_addr, imem_data);
      if (q.size() == 0) chk("main_unexpected_write", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("main_addr", 64'(imem_addr), 64'(e.addr));
        chk("main_data", 64'(imem_data), 64'(e.data));
      end
    end
    if (imem_wren2) begin
      $display("write small addr=%0h data=%08h", imem_addr2, imem_data2);
      if (q2.size() == 0) chk("small_unexpected_write", 1, 0);
      else begin
        exp_t e;
        e = q2.pop_front();
        chk("small_addr", 64'(imem_addr2), 64'(e.addr[1:0]));
        chk("small_data", 64'(imem_data2), 64'(e.data));
      end
    end
  end

  task automatic set_fields(input logic [4:0] op, rd, rs, rt, sh, alu,
                            input logic [16:0] imm, input logic [26:0] tgt);
    in_opcode = op; in_rd = rd; in_rs = rs; in_rt = rt; in_shamt = sh; in_alu_op = alu;
    in_imm = imm; in_target = tgt;
  endtask

  task automatic do_start();
    start = 1;
    @(negedge clock);
    start = 0;
    m_ptr = 0; m_wc = 0; m_ill = 0;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [4:0] op, rd, rs, rt, sh, alu,
                      input logic [16:0] imm, input logic [26:0] tgt, input bit last);
    exp_t e;
    bit   bad;
    int   n;
    set_fields(op, rd, rs, rt, sh, alu, imm, tgt);
    in_last  = last;
    in_valid = 1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      chk("ready_timeout", 0, 1);
      in_valid = 0;
      return;
    end
    e.addr = 12'(m_ptr);
    e.data = model_word(op, rd, rs, rt, sh, alu, imm, tgt, bad);
    q.push_back(e);
    m_ptr++; m_wc++; m_ill |= bad;
    @(posedge clock);
    @(negedge clock);
    in_valid = 0;
    in_last  = 0;
  endtask

  task automatic send_random(input bit last);
    logic [4:0] ops [13];
    ops = '{5'd0, 5'd1, 5'd3, 5'd21, 5'd22, 5'd4, 5'd2, 5'd5, 5'd6, 5'd7, 5'd8, 5'd15, 5'd31};
    send(ops[$urandom_range(0, 12)], 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
         5'($urandom), 17'($urandom), 27'($urandom), last);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_wren", imem_wren, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_wc", word_count, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_data", imem_data, 0);
    chk("rst_errs", {err_illegal, err_overflow}, 0);
    reset = 0;
    @(negedge clock);

    // Single R-type program
    do_start();
    chk("load_busy", busy, 1);
    send(5'd0, 5'd3, 5'd1, 5'd2, 5'd0, 5'd0, 17'd0, 27'd0, 1);
    chk("r_done", done, 1);
    chk("r_busy", busy, 0);
    chk("r_wc", word_count, 1);

    // addi then jump, with a start pulse mid-session that must be ignored
    do_start();
    send(5'b00101, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 17'h1FFFF, 27'd0, 0);
    start = 1;
    @(negedge clock);
    start = 0;
    send(5'b00001, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'h123, 1);
    chk("ij_wc", word_count, 2);
    chk("ij_done", done, 1);
    chk("ij_illegal", err_illegal, 0);

    // Illegal opcode, then a new start clears the flag
    do_start();
    send(5'b01111, 5'd7, 5'd7, 5'd7, 5'd7, 5'd7, 17'h1234, 27'h555, 1);
    chk("illegal_flag", err_illegal, 1);
    do_start();
    chk("illegal_cleared", err_illegal, 0);
    send(5'b00100, 5'd9, 5'd3, 5'd0, 5'd0, 5'd0, 17'd0, 27'd0, 1);

    // Random program with random valid gaps
    do_start();
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clock);
      send_random(i == 7);
    end
    chk("rand_wc", word_count, 13'(m_wc));
    chk("rand_done", done, 1);
    chk("rand_illegal", err_illegal, m_ill);

    // Overflow on the 4-word instance: fifth tuple must be refused
    start2 = 1;
    @(negedge clock);
    start2 = 0;
    for (int i = 0; i < 5; i++) begin
      exp_t e;
      bit bad;
      set_fields(5'd0, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 17'd0, 27'd0);
      in_valid2 = 1;
      chk("ovf_ready", in_ready2, (i < 4));
      if (in_ready2) begin
        e.addr = 12'(i);
        e.data = model_word(in_opcode, in_rd, in_rs, in_rt, in_shamt, in_alu_op, in_imm, in_target, bad);
        q2.push_back(e);
      end
      @(posedge clock);
      @(negedge clock);
    end
    in_valid2 = 0;
    chk("ovf_flag", err_overflow2, 1);
    chk("ovf_done", done2, 1);
    chk("ovf_wc", word_count2, 4);

    // Filling exactly to the top with in_last is not an overflow
    start2 = 1;
    @(negedge clock);
    start2 = 0;
    chk("ovf_cleared", err_overflow2, 0);
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      bit bad;
      set_fields(5'b00010, 5'($urandom), 5'($urandom), 5'd0, 5'd0, 5'd0, 17'($urandom), 27'd0);
      in_valid2 = 1;
      in_last2  = (i == 3);
      e.addr = 12'(i);
      e.data = model_word(in_opcode, in_rd, in_rs, in_rt, in_shamt, in_alu_op, in_imm, in_target, bad);
      q2.push_back(e);
      @(posedge clock);
      @(negedge clock);
    end
    in_valid2 = 0;
    in_last2  = 0;
    chk("full_noerr", err_overflow2, 0);
    chk("full_done", done2, 1);
    chk("full_wc", word_count2, 4);

    // Reset arriving with a presented tuple drops it
    do_start();
    send(5'b00110, 5'd2, 5'd4, 5'd0, 5'd0, 5'd0, 17'h00abc, 27'd0, 0);
    set_fields(5'b00000, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 17'd0, 27'd0);
    in_valid = 1;
    reset = 1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 0;
    chk("mid_rst_wren", imem_wren, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wc", word_count, 0);
    reset = 0;

    repeat (5) @(negedge clock);
    chk("queue_drained", 64'(q.size() + q2.size()), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
